// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared types and constants for the programmable clock divider
package clk_div_pkg;
    localparam int DIV_W_DEFAULT = 8;
    localparam int MIN_RATIO     = 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOPPING
    } state_t;
endpackage

// File: rtl/clk_div_gen_if.sv
// rtl/clk_div_gen_if.sv - ratio configuration channel (valid/ready plus sticky error)
interface clk_div_gen_if #(
    parameter int DIV_W = clk_div_pkg::DIV_W_DEFAULT
);
    logic [DIV_W-1:0] ratio_in;
    logic             ratio_valid;
    logic             ratio_ready;
    logic             cfg_err;

    modport master (
        output ratio_in,
        output ratio_valid,
        input  ratio_ready,
        input  cfg_err
    );

    modport slave (
        input  ratio_in,
        input  ratio_valid,
        output ratio_ready,
        output cfg_err
    );
endinterface

// File: rtl/clk_div_shadow.sv
// rtl/clk_div_shadow.sv - one-entry pending ratio register with clamp and sticky error
module clk_div_shadow
    import clk_div_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEFAULT
) (
    input  logic             clk_in,
    input  logic             rst,
    clk_div_gen_if.slave     cfg,
    input  logic             bypass,
    input  logic             consume,
    output logic             accept,
    output logic [DIV_W-1:0] ratio_clamped,
    output logic             pending_valid,
    output logic [DIV_W-1:0] pending_ratio
);
    logic ready_en;
    logic err_q;
    logic too_low;

    assign too_low         = cfg.ratio_in < DIV_W'(MIN_RATIO);
    assign ratio_clamped   = too_low ? DIV_W'(MIN_RATIO) : cfg.ratio_in;
    assign cfg.ratio_ready = ready_en && !pending_valid;
    assign accept          = cfg.ratio_valid && cfg.ratio_ready;
    assign cfg.cfg_err     = err_q;

    // A bypassed accept is consumed directly by the divider and never occupies the slot
    always_ff @(posedge clk_in) begin
        if (rst) begin
            ready_en      <= 1'b0;
            err_q         <= 1'b0;
            pending_valid <= 1'b0;
            pending_ratio <= '0;
        end else begin
            ready_en <= 1'b1;
            if (accept && too_low) begin
                err_q <= 1'b1;
            end
            if (accept && !bypass) begin
                pending_valid <= 1'b1;
                pending_ratio <= ratio_clamped;
            end else if (consume) begin
                pending_valid <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/clk_div_gen.sv
// rtl/clk_div_gen.sv - glitch-free programmable integer clock divider with registered output
module clk_div_gen
    import clk_div_pkg::*;
#(
    parameter int DIV_W         = DIV_W_DEFAULT,
    parameter int DEFAULT_RATIO = 2
) (
    input  logic         clk_in,
    input  logic         rst,
    input  logic         en,
    clk_div_gen_if.slave cfg,
    output logic         clk_out,
    output logic         tick,
    output logic         active
);
    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] ratio_q, ratio_d;
    logic [DIV_W-1:0] high_len;
    logic [DIV_W-1:0] ratio_clamped;
    logic [DIV_W-1:0] pending_ratio;
    logic             pending_valid;
    logic             accept;
    logic             bypass;
    logic             consume;
    logic             wrap;
    logic             clk_d;
    logic             tick_d;

    clk_div_shadow #(.DIV_W(DIV_W)) u_shadow (
        .clk_in        (clk_in),
        .rst           (rst),
        .cfg           (cfg),
        .bypass        (bypass),
        .consume       (consume),
        .accept        (accept),
        .ratio_clamped (ratio_clamped),
        .pending_valid (pending_valid),
        .pending_ratio (pending_ratio)
    );

    // Odd ratios give the spare cycle to the high phase
    assign high_len = (ratio_q >> 1) + {{(DIV_W-1){1'b0}}, ratio_q[0]};
    assign wrap     = (state_q != IDLE) && (cnt_q == ratio_q - DIV_W'(1));
    assign bypass   = (state_q == IDLE) && en;
    assign consume  = pending_valid && ((state_q == IDLE) || wrap);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ratio_d = ratio_q;
        clk_d   = 1'b0;
        tick_d  = 1'b0;
        if (consume) begin
            ratio_d = pending_ratio;
        end
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (en) begin
                    state_d = RUN;
                    clk_d   = 1'b1;
                    tick_d  = 1'b1;
                    if (accept) begin
                        ratio_d = ratio_clamped;
                    end
                end
            end
            RUN, STOPPING: begin
                if (wrap) begin
                    cnt_d  = '0;
                    clk_d  = 1'b1;
                    tick_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                    clk_d = (cnt_q + DIV_W'(1)) < high_len;
                end
                // Stopping only ends on a wrap, after the full low phase has been emitted
                if (en) begin
                    state_d = RUN;
                end else if (state_q == STOPPING && wrap) begin
                    state_d = IDLE;
                    clk_d   = 1'b0;
                    tick_d  = 1'b0;
                end else begin
                    state_d = STOPPING;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ratio_q <= DIV_W'(DEFAULT_RATIO);
            clk_out <= 1'b0;
            tick    <= 1'b0;
            active  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ratio_q <= ratio_d;
            clk_out <= clk_d;
            tick    <= tick_d;
            active  <= (state_d != IDLE);
        end
    end
endmodule

// File: tb/tb_clk_div_gen.sv
// tb/tb_clk_div_gen.sv - self-checking bench for clk_div_gen against a period-position model
module tb_clk_div_gen;
    logic clk_in = 1'b0;
    logic rst;
    logic en;
    logic clk_out;
    logic tick;
    logic active;

    clk_div_gen_if #(.DIV_W(8)) cfg ();

    clk_div_gen #(.DIV_W(8), .DEFAULT_RATIO(2)) dut (
        .clk_in  (clk_in),
        .rst     (rst),
        .en      (en),
        .cfg     (cfg),
        .clk_out (clk_out),
        .tick    (tick),
        .active  (active)
    );

    always #5 clk_in = ~clk_in;

    int total;
    int bad;

    // Model: is a waveform being produced, where in the period are we, which ratio
    bit m_on;
    int m_pos;
    int m_n;
    bit m_stop;
    bit m_pend_v;
    int m_pend_n;
    bit m_rdy_en;
    bit m_err;

    task automatic model_step(input bit r, input bit e, input bit v, input int rin);
        bit acc;
        int cn;
        if (r) begin
            m_on = 0; m_pos = 0; m_n = 2; m_stop = 0;
            m_pend_v = 0; m_pend_n = 0; m_rdy_en = 0; m_err = 0;
            return;
        end
        acc = v && m_rdy_en && !m_pend_v;
        cn  = (rin < 2) ? 2 : rin;
        if (acc && rin < 2) m_err = 1;
        if (!m_on) begin
            if (e) begin
                m_on = 1; m_pos = 0; m_stop = 0;
                if (acc) m_n = cn;
                else if (m_pend_v) begin m_n = m_pend_n; m_pend_v = 0; end
            end else begin
                if (m_pend_v) begin m_n = m_pend_n; m_pend_v = 0; end
                if (acc) begin m_pend_v = 1; m_pend_n = cn; end
            end
        end else begin
            if (m_pos == m_n - 1) begin
                m_pos = 0;
                if (m_stop && !e) m_on = 0;
                if (m_pend_v) begin m_n = m_pend_n; m_pend_v = 0; end
            end else begin
                m_pos = m_pos + 1;
            end
            m_stop = !e;
            if (acc) begin m_pend_v = 1; m_pend_n = cn; end
        end
        m_rdy_en = 1;
    endtask

    task automatic cmp(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        cmp("clk_out", int'(clk_out), int'(m_on && (m_pos < (m_n + 1) / 2)));
        cmp("tick", int'(tick), int'(m_on && m_pos == 0));
        cmp("active", int'(active), int'(m_on));
        cmp("ratio_ready", int'(cfg.ratio_ready), int'(m_rdy_en && !m_pend_v));
        cmp("cfg_err", int'(cfg.cfg_err), int'(m_err));
    endtask

    task automatic cycle(input bit r, input bit e, input bit v, input int rin);
        rst = r;
        en = e;
        cfg.ratio_valid = v;
        cfg.ratio_in = rin[7:0];
        model_step(r, e, v, rin);
        @(posedge clk_in);
        #1;
        check_model();
    endtask

    logic [3:0] pat4, tck4;
    logic [9:0] pat10, tck10;
    bit r_en;

    initial begin
        total = 0;
        bad = 0;
        model_step(1, 0, 0, 0);
        rst = 1; en = 0; cfg.ratio_valid = 0; cfg.ratio_in = '0;

        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cmp("rst_clk_out", int'(clk_out), 0);
        cmp("rst_active", int'(active), 0);
        cmp("rst_ready", int'(cfg.ratio_ready), 0);
        cycle(0, 0, 0, 0);
        cmp("ready_after_rst", int'(cfg.ratio_ready), 1);

        // Default ratio 2
        pat4 = '0; tck4 = '0;
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, 0, 0);
            pat4 = {pat4[2:0], clk_out};
            tck4 = {tck4[2:0], tick};
        end
        cmp("n2_clk_pattern", int'(pat4), 4'b1010);
        cmp("n2_tick_pattern", int'(tck4), 4'b1010);
        cmp("n2_active", int'(active), 1);

        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0);
        cmp("stopped_active", int'(active), 0);

        // Ratio 5 accepted in IDLE, then started
        cycle(0, 0, 1, 5);
        cmp("pending_ready_low", int'(cfg.ratio_ready), 0);
        pat10 = '0; tck10 = '0;
        for (int i = 0; i < 10; i++) begin
            cycle(0, 1, 0, 0);
            pat10 = {pat10[8:0], clk_out};
            tck10 = {tck10[8:0], tick};
        end
        cmp("n5_clk_pattern", int'(pat10), 10'b1110011100);
        cmp("n5_tick_pattern", int'(tck10), 10'b1000010000);
        cmp("n5_ready_back", int'(cfg.ratio_ready), 1);

        // Ratio 0 is clamped and flags a sticky error
        cycle(0, 1, 1, 0);
        cmp("cfg_err_set", int'(cfg.cfg_err), 1);
        for (int i = 0; i < 12; i++) cycle(0, 1, 0, 0);
        cmp("cfg_err_sticky", int'(cfg.cfg_err), 1);

        cycle(1, 1, 0, 0);
        cmp("midrun_rst_clk", int'(clk_out), 0);
        cmp("midrun_rst_active", int'(active), 0);
        cmp("midrun_rst_err", int'(cfg.cfg_err), 0);

        r_en = 0;
        for (int i = 0; i < 6000; i++) begin
            int rin;
            bit v;
            bit r;
            if ($urandom_range(0, 15) == 0) r_en = !r_en;
            v = ($urandom_range(0, 3) == 0);
            rin = ($urandom_range(0, 49) == 0) ? int'($urandom_range(200, 255))
                                                : int'($urandom_range(0, 12));
            r = ($urandom_range(0, 499) == 0);
            cycle(r, r_en, v, rin);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/clk_div_gen.md
Name: clk_div_gen

Overview:
- Programmable integer clock divider with glitch-free start/stop, directly upstream of clk_buffer.
- Its clk_out drives the buffer's clk_in.
- Output is a register clocked by clk_in, so clk_out never carries a truncated pulse.
- Ratio changes go through a valid/ready shadow register and take effect only on a period boundary.

Parameters:
- DIV_W, 8: width of the divide ratio.
- DEFAULT_RATIO, 2: active ratio after reset. Must be >= 2.

Ports:
- clk_in  input  1  source clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  run request. Level-sensitive.
- ratio_in  input  DIV_W  requested divide ratio N.
- ratio_valid  input  1  ratio_in offered.
- ratio_ready  output  1  shadow register empty; transfer occurs on valid&&ready.
- clk_out  output  1  divided clock, registered.
- tick  output  1  one-cycle pulse coinciding with the first high cycle of each clk_out period.
- active  output  1  high in RUN or STOPPING.
- cfg_err  output  1  sticky: a ratio below 2 was accepted.

Behaviour:
- Reset (rst=1 at an edge):
  - clk_out=0, tick=0, active=0, cfg_err=0, ratio_ready=0.
  - Active ratio=DEFAULT_RATIO, pending cleared, cnt=0, state=IDLE.
  - ratio_ready=1 from the first edge after rst drops.
  - Reset mid-period truncates immediately; this is the only permitted truncation.
- Waveform for active ratio N:
  - H=ceil(N/2), L=floor(N/2).
  - cnt runs 0..N-1; clk_out=1 while cnt<H.
  - Odd N gives the extra cycle to the high phase.
- Period boundary: the edge where cnt wraps N-1→0, or where RUN is entered from IDLE.
- States:
  - IDLE: clk_out=0, cnt=0. en=1 sampled → RUN. clk_out=1 and tick=1 at the next edge (1-cycle latency).
  - RUN: free-running. en=0 sampled → STOPPING. The current period continues unchanged.
  - STOPPING: complete the current period, including the full low phase.
    - At the wrap edge → IDLE; clk_out stays 0.
    - If en=1 is sampled before the wrap → RUN, with no gap and no extra cycle.
    - If en=0 arrives exactly on the wrap edge → STOPPING, then IDLE after one more full period.
- Ratio handshake:
  - One-entry pending register.
  - ratio_ready=!pending_valid.
  - Accept stores ratio_in and clears ratio_ready.
- Ratio application:
  - In IDLE: pending applies at the next edge.
  - If a ratio is accepted in the same cycle en rises in IDLE, the first period already uses the new ratio.
  - In RUN or STOPPING: pending applies at the next period boundary, which then releases ratio_ready.
  - A ratio accepted on the wrap edge itself waits one full period.
- Ratio clamp:
  - ratio_in<2 (0 or 1) is clamped to 2 and sets cfg_err.
  - cfg_err clears only on rst.
- Maximum ratio is 2^DIV_W−1. cnt is DIV_W bits and never exceeds N−1.
- active=1 in RUN and STOPPING.
- clk_out, tick and active are all registered; no combinational path from inputs to outputs.

Decomposition:
- Package clk_div_pkg:
  - State enum {IDLE, RUN, STOPPING}.
  - MIN_RATIO=2.
  - Default DIV_W.
- One natural sub-module, clk_div_shadow: pending register, valid/ready, clamp and cfg_err.
- The FSM, counter and output register stay in clk_div_gen.

Test Plan:
- Reset, then en=1 with N=2 → clk_out goes 1,0,1,0…; tick on every high cycle; first high 1 cycle after en is sampled; active=1.
- Accept N=5 while IDLE, then en=1 → high 3 cycles, low 2 cycles, period 5; tick once per 5 cycles.
- Running N=4: accept N=6 mid-period → current period completes as 2H/2L; next period is 3H/3L; ratio_ready low until that boundary, then high.
- Running N=6: drop en at cnt=1 → period completes (3H/3L) then IDLE; active falls at the wrap. Repeat, re-asserting en at cnt=4 → continuous waveform, no gap.
- Accept ratio_in=0 → cfg_err=1 sticky; behaves as N=2. Second valid during pending → ratio_ready=0, no overwrite.
- Assert rst during the high phase of N=8 → next edge clk_out=0, active=0, ratio=DEFAULT_RATIO, cfg_err=0.
